// File: rtl/branch_resolve_ctrl.sv
// rtl/branch_resolve_ctrl.sv - in-flight branch prediction queue with mispredict recovery
// Ports: CLK/nRST; pred_* push side from fetch (pred_ready = accept);
// res_* resolve side from execute (pops oldest entry); flush/redirect_pc recovery
// pulse to fetch; q_empty, sticky underflow_err, saturating branch/mispredict counters.
module branch_resolve_ctrl #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             pred_valid,
  input  logic             pred_taken,
  input  logic [31:0]      pred_target,
  input  logic [31:0]      pred_fallthru,
  output logic             pred_ready,
  input  logic             res_valid,
  input  logic             res_taken,
  input  logic [31:0]      res_target,
  output logic             flush,
  output logic [31:0]      redirect_pc,
  output logic             q_empty,
  output logic             underflow_err,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0]    PTR_ONE = AW'(1);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);
  localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
  localparam logic [CNT_W-1:0] STAT_ONE = CNT_W'(1);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
    logic [31:0] fallthru;
  } entry_t;

  entry_t mem_q [DEPTH];

  state_t           state_q, state_d;
  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             flush_q, flush_d;
  logic [31:0]      redirect_q, redirect_d;
  logic             q_empty_q, q_empty_d;
  logic             underflow_q, underflow_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  entry_t head_e;
  logic   push, pop, mispredict, mem_we;

  // Ready depends only on registered state, so fetch never sees a combinational path.
  assign pred_ready = (state_q == RUN) && (count_q < DEPTH_C);
  assign head_e     = mem_q[head_q];
  assign push       = pred_valid && pred_ready;
  assign pop        = res_valid && (count_q != '0) && (state_q == RUN);
  assign mispredict = pop && ((res_taken != head_e.taken) ||
                              (res_taken && head_e.taken && (res_target != head_e.target)));
  // A push coinciding with a mispredict is wrong-path and is never written.
  assign mem_we     = push && !mispredict;

  always_comb begin
    state_d       = RUN;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    flush_d       = 1'b0;
    redirect_d    = redirect_q;
    underflow_d   = underflow_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;

    if (state_q == RUN) begin
      if (res_valid && (count_q == '0)) begin
        underflow_d = 1'b1;
      end
      if (pop) begin
        if (branch_cnt_q != '1) branch_cnt_d = branch_cnt_q + STAT_ONE;
      end
      if (mispredict) begin
        if (mispred_cnt_q != '1) mispred_cnt_d = mispred_cnt_q + STAT_ONE;
        state_d    = FLUSH;
        head_d     = '0;
        tail_d     = '0;
        count_d    = '0;
        flush_d    = 1'b1;
        redirect_d = res_taken ? res_target : head_e.fallthru;
      end else begin
        if (push) tail_d = tail_q + PTR_ONE;
        if (pop)  head_d = head_q + PTR_ONE;
        case ({push, pop})
          2'b10:   count_d = count_q + CNT_ONE;
          2'b01:   count_d = count_q - CNT_ONE;
          default: count_d = count_q;
        endcase
      end
    end
    q_empty_d = (count_d == '0);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q       <= RUN;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      flush_q       <= 1'b0;
      redirect_q    <= '0;
      q_empty_q     <= 1'b1;
      underflow_q   <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      flush_q       <= flush_d;
      redirect_q    <= redirect_d;
      q_empty_q     <= q_empty_d;
      underflow_q   <= underflow_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  // Entry storage needs no reset: pointers and count define which slots are live.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[tail_q] <= '{taken: pred_taken, target: pred_target, fallthru: pred_fallthru};
    end
  end

  assign flush          = flush_q;
  assign redirect_pc    = redirect_q;
  assign q_empty        = q_empty_q;
  assign underflow_err  = underflow_q;
  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb/tb_branch_resolve_ctrl.sv - randomized and directed bench for branch_resolve_ctrl
module tb_branch_resolve_ctrl;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        pred_valid = 1'b0, pred_taken = 1'b0;
  logic [31:0] pred_target = '0, pred_fallthru = '0;
  logic        res_valid = 1'b0, res_taken = 1'b0;
  logic [31:0] res_target = '0;

  logic        pred_ready, flush, q_empty, underflow_err;
  logic [31:0] redirect_pc, branch_cnt, mispredict_cnt;
  logic        pred_ready4, flush4, q_empty4, underflow_err4;
  logic [31:0] redirect_pc4;
  logic [3:0]  branch_cnt4, mispredict_cnt4;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  branch_resolve_ctrl #(.DEPTH(DEPTH), .CNT_W(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
    .pred_fallthru(pred_fallthru), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .flush(flush), .redirect_pc(redirect_pc), .q_empty(q_empty),
    .underflow_err(underflow_err), .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  branch_resolve_ctrl #(.DEPTH(DEPTH), .CNT_W(4)) dut4 (
    .CLK(CLK), .nRST(nRST),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
    .pred_fallthru(pred_fallthru), .pred_ready(pred_ready4),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .flush(flush4), .redirect_pc(redirect_pc4), .q_empty(q_empty4),
    .underflow_err(underflow_err4), .branch_cnt(branch_cnt4), .mispredict_cnt(mispredict_cnt4)
  );

  // Reference model: a plain queue of predictions plus integer statistics.
  typedef struct {
    logic        t;
    logic [31:0] tgt;
    logic [31:0] ft;
  } ent_t;

  ent_t        mq[$];
  bit          m_flush;
  bit          m_uf;
  longint      m_bc, m_mc;
  logic [31:0] m_redir;

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_flush = 0;
    m_uf    = 0;
    m_bc    = 0;
    m_mc    = 0;
    m_redir = '0;
  endtask

  task automatic check_outputs();
    chk("flush", flush, m_flush);
    chk("flush4", flush4, m_flush);
    if (m_flush) chk("redirect_pc", redirect_pc, m_redir);
    chk("q_empty", q_empty, mq.size() == 0);
    chk("underflow_err", underflow_err, m_uf);
    chk("branch_cnt", branch_cnt, sat(m_bc, 32));
    chk("mispredict_cnt", mispredict_cnt, sat(m_mc, 32));
    chk("branch_cnt4", branch_cnt4, sat(m_bc, 4));
    chk("mispredict_cnt4", mispredict_cnt4, sat(m_mc, 4));
  endtask

  // One clock: drive inputs, check ready, let the edge happen, update model, check outputs.
  task automatic step(input logic pv, input logic pt, input logic [31:0] ptg, input logic [31:0] pf,
                      input logic rv, input logic rt, input logic [31:0] rtg);
    bit   exp_ready, mis;
    ent_t e;
    pred_valid = pv; pred_taken = pt; pred_target = ptg; pred_fallthru = pf;
    res_valid = rv; res_taken = rt; res_target = rtg;
    exp_ready = !m_flush && (mq.size() < DEPTH);
    #1;
    chk("pred_ready", pred_ready, exp_ready);
    @(posedge CLK);
    if (m_flush) begin
      m_flush = 0;
    end else begin
      mis = 0;
      if (rv) begin
        if (mq.size() == 0) begin
          m_uf = 1;
        end else begin
          e = mq[0];
          mis = (rt != e.t) || (rt && e.t && rtg != e.tgt);
          m_bc++;
          if (mis) begin
            m_mc++;
            m_redir = rt ? rtg : e.ft;
            m_flush = 1;
            mq.delete();
          end else begin
            void'(mq.pop_front());
          end
        end
      end
      if (!mis && pv && exp_ready) mq.push_back('{t: pt, tgt: ptg, ft: pf});
    end
    @(negedge CLK);
    check_outputs();
  endtask

  task automatic idle();
    step(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
  endtask

  task automatic do_reset();
    pred_valid = 0; res_valid = 0;
    @(negedge CLK);
    nRST = 0;
    model_reset();
    repeat (2) @(negedge CLK);
    nRST = 1;
    #1;
    check_outputs();
    chk("rst_redirect", redirect_pc, 32'h0);
    chk("rst_ready", pred_ready, 1'b1);
  endtask

  initial begin
    model_reset();
    do_reset();

    // Fill with four not-taken branches, then drain them all correctly.
    for (int i = 0; i < 4; i++) step(1, 0, 32'h200, 32'h104 + 32'(4 * i), 0, 0, 32'h0);
    chk("full_ready", pred_ready, 1'b0);
    for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 32'h0, 1, 0, 32'h0);
    chk("drain_bc", branch_cnt, 32'd4);
    chk("drain_mc", mispredict_cnt, 32'd0);
    chk("drain_empty", q_empty, 1'b1);

    // Correct taken branch, then a not-taken prediction resolved taken.
    step(1, 1, 32'h0F0, 32'h0F4, 0, 0, 32'h0);
    step(0, 0, 32'h0, 32'h0, 1, 1, 32'h0F0);
    step(1, 0, 32'h1F0, 32'h204, 0, 0, 32'h0);
    step(0, 0, 32'h0, 32'h0, 1, 1, 32'h300);
    chk("redir_300", redirect_pc, 32'h300);
    idle();
    chk("flush_one_cycle", flush, 1'b0);

    // Taken prediction resolved not taken flushes two younger entries.
    do_reset();
    step(1, 1, 32'h400, 32'h504, 0, 0, 32'h0);
    step(1, 0, 32'h600, 32'h508, 0, 0, 32'h0);
    step(1, 1, 32'h700, 32'h50C, 0, 0, 32'h0);
    step(0, 0, 32'h0, 32'h0, 1, 0, 32'h0);
    chk("redir_504", redirect_pc, 32'h504);
    idle();
    chk("flushed_empty", q_empty, 1'b1);
    chk("flush_mc", mispredict_cnt, 32'd1);
    chk("flush_bc", branch_cnt, 32'd1);

    // Full queue: push with a correct pop is rejected; then steady push+pop at count 2.
    for (int i = 0; i < 4; i++) step(1, 0, 32'h0, 32'h800 + 32'(4 * i), 0, 0, 32'h0);
    step(1, 0, 32'h0, 32'h900, 1, 0, 32'h0);
    step(0, 0, 32'h0, 32'h0, 1, 0, 32'h0);
    for (int i = 0; i < 10; i++) step(1, 0, 32'h0, 32'hA00 + 32'(4 * i), 1, 0, 32'h0);
    step(0, 0, 32'h0, 32'h0, 1, 0, 32'h0);
    step(0, 0, 32'h0, 32'h0, 1, 0, 32'h0);
    chk("steady_empty", q_empty, 1'b1);

    // Underflow, mispredict with res_valid held into FLUSH, then reset mid-flush.
    do_reset();
    step(0, 0, 32'h0, 32'h0, 1, 0, 32'h0);
    chk("uf_set", underflow_err, 1'b1);
    chk("uf_bc", branch_cnt, 32'd0);
    step(1, 0, 32'h0, 32'hB04, 0, 0, 32'h0);
    step(0, 0, 32'h0, 32'h0, 1, 1, 32'hC00);
    step(0, 0, 32'h0, 32'h0, 1, 1, 32'hC00);
    chk("held_bc", branch_cnt, 32'd1);
    step(1, 1, 32'hD00, 32'hD04, 0, 0, 32'h0);
    step(0, 0, 32'h0, 32'h0, 1, 0, 32'h0);
    chk("pre_rst_flush", flush, 1'b1);
    #1 nRST = 0;
    #1;
    model_reset();
    check_outputs();
    chk("rst_flush_redirect", redirect_pc, 32'h0);
    chk("rst_flush_ready", pred_ready, 1'b1);
    @(negedge CLK);
    nRST = 1;

    // Random traffic against the queue model; also drives the 4-bit counters into saturation.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 3) != 0, $urandom % 2,
           ($urandom % 2) ? 32'h1000 : 32'h2000, 32'h3000 + 32'($urandom % 256) * 4,
           ($urandom % 2) == 1, $urandom % 2, ($urandom % 2) ? 32'h1000 : 32'h2000);
    end
    if (m_bc >= 16) chk("sat4_bc", branch_cnt4, 4'hF);
    idle();
    if (m_bc >= 16) chk("sat4_hold", branch_cnt4, 4'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
# branch_resolve_ctrl

Tracks in-flight branch predictions between fetch and execute, checks each prediction against the resolved outcome, and sequences pipeline recovery on a mispredict. It sits beside the static predictor:
- Fetch pushes every prediction the predictor makes.
- Execute pops entries in program order as branches resolve.
- On a mispredict this block produces a registered flush pulse and redirect PC for the fetch stage, then discards all younger wrong-path entries.
- It also keeps saturating branch and mispredict counters for performance CSRs.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- CNT_W, 32, width of the statistics counters.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  asynchronous, active-low reset.
- pred_valid  in  1  fetch pushes one predicted branch.
- pred_taken  in  1  predicted direction.
- pred_target  in  32  predicted target (pc + sign-extended offset).
- pred_fallthru  in  32  sequential PC (pc + 4).
- pred_ready  out  1  push accepted this cycle.
- res_valid  in  1  execute resolves the oldest queued branch.
- res_taken  in  1  actual direction.
- res_target  in  32  actual computed target.
- flush  out  1  one-cycle recovery pulse to fetch and decode.
- redirect_pc  out  32  PC to fetch from; valid only while flush = 1.
- q_empty  out  1  queue holds no entries.
- underflow_err  out  1  sticky; set by res_valid while the queue is empty.
- branch_cnt  out  CNT_W  resolved branches, saturating.
- mispredict_cnt  out  CNT_W  mispredicted branches, saturating.

## Operation
- The queue is a circular FIFO with head and tail pointers of log2(DEPTH) bits plus a count of log2(DEPTH)+1 bits. Each entry holds {taken, target, fallthru}.
- pred_ready = (state == RUN) && (count < DEPTH). It is computed from registered state only.
- There is no same-cycle bypass: a pop does not make room for a push in the same cycle.
- A push occurs when pred_valid && pred_ready.
- A pop occurs when res_valid && !q_empty && state == RUN.
- Mispredict test on the head entry E:
  - (res_taken != E.taken) is a mispredict.
  - (res_taken && E.taken && res_target != E.target) is also a mispredict.
- Redirect target on a mispredict: res_taken ? res_target : E.fallthru.
- Counters, on every pop:
  - branch_cnt increments.
  - mispredict_cnt increments if the pop is a mispredict.
  - Both counters hold at all-ones once they reach it.
- FSM states: RUN, FLUSH.
  - RUN to FLUSH: a pop that mispredicts. In the same edge, head, tail and count are cleared, any simultaneous push is dropped (it is wrong-path), and redirect_pc is registered.
  - FLUSH to RUN: unconditional after one cycle.
  - While in FLUSH: flush = 1, pred_ready = 0, and res_valid is ignored (no pop, no counting, no error).
- res_valid with q_empty in RUN: no pop and no count; underflow_err sets and stays set until reset.
- Push and a correctly predicted pop in the same cycle: count is unchanged and both pointers advance.

## Timing
- Reset values: state RUN, queue empty, pred_ready = 1, flush = 0, redirect_pc = 0, q_empty = 1, underflow_err = 0, both counters 0.
- Reset takes effect asynchronously and mid-flush: it clears flush immediately and discards all entries.
- Push latency: an entry pushed at edge N can be popped by res_valid in cycle N+1.
- Mispredict latency: a mispredicting pop resolved at edge N produces flush = 1 and a valid redirect_pc during cycle N+1, for exactly one cycle.
- The first push after recovery is accepted in cycle N+2.
- flush, redirect_pc, q_empty and underflow_err are registered outputs.
- Pointers wrap modulo DEPTH. Full is count == DEPTH and empty is count == 0; full and empty are never inferred from pointer equality.

## Test plan
- Reset, then push 4 not-taken entries with fallthru 0x104, 0x108, 0x10C, 0x110 -> pred_ready = 0 after the 4th push; pop all 4 as not taken -> no flush, branch_cnt = 4, mispredict_cnt = 0, q_empty = 1.
- Push {taken, target 0x0F0}, resolve taken with target 0x0F0 -> no flush. Then push {not taken, fallthru 0x204}, resolve taken with target 0x300 -> flush = 1 for exactly one cycle with redirect_pc = 0x300, and pred_ready = 0 in that cycle.
- Push {taken, target 0x400, fallthru 0x504} plus 2 younger entries, resolve not taken -> redirect_pc = 0x504, queue empty after the flush cycle, mispredict_cnt = 1, branch_cnt = 1.
- Queue full (count 4): assert push and correct pop in the same cycle -> push rejected, count = 3; with count 2, push and pop together -> count stays 2 and the pointers wrap correctly across 10 iterations.
- res_valid while empty -> underflow_err = 1 and counters unchanged; then a mispredicting pop during which res_valid is held high into the FLUSH cycle -> only one pop counted. Assert nRST low during FLUSH -> flush drops immediately and all outputs take their reset values.
- Force both counters to saturation with CNT_W = 4: after 16 pops branch_cnt = 15 and stays 15.
